mem_arbiter: RTL and testbench

Two-port arbiter sharing the single-port 8-bit `memory` between the CPU `data_path` (port 0) and a debug/program-loader master (port 1). It sits between both masters and `memory`, and owns the memory address, write-data and write-enable lines. It arbitrates round-robin per cycle and supports a locked sequence for atomic multi-cycle access, bounded by a lock timeout. It returns read data one cycle after the access is accepted, with a per-port valid strobe.

---
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory.
// Port 0 is the CPU data path, port 1 the debug/program loader. A port may
// lock the memory for an atomic multi-cycle sequence; the lock is forcibly
// dropped after MAX_LOCK cycles so the other master cannot be starved.
module mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_p0_req,
  input  logic          i_p0_we,
  input  logic [AW-1:0] i_p0_addr,
  input  logic [DW-1:0] i_p0_wdata,
  input  logic          i_p0_lock,
  input  logic          i_p1_req,
  input  logic          i_p1_we,
  input  logic [AW-1:0] i_p1_addr,
  input  logic [DW-1:0] i_p1_wdata,
  input  logic          i_p1_lock,
  output logic          o_p0_gnt,
  output logic          o_p1_gnt,
  output logic          o_p0_rvalid,
  output logic          o_p1_rvalid,
  output logic [DW-1:0] o_p0_rdata,
  output logic [DW-1:0] o_p1_rdata,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_data_write,
  output logic          o_mem_we,
  input  logic [DW-1:0] i_mem_data_read,
  output logic          o_lock_timeout
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t        state, state_nx;
  logic          last, last_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          tmo, tmo_nx;
  logic          rv0, rv1;
  logic          gnt0, gnt1, acc0, acc1;

  // Grant: round-robin on ties in IDLE, owner-only while locked, none in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!i_rst) begin
      case (state)
        IDLE: begin
          if (i_p0_req && i_p1_req) begin
            gnt0 = last;   // last served was port 1 -> port 0's turn
            gnt1 = ~last;
          end else begin
            gnt0 = i_p0_req;
            gnt1 = i_p1_req;
          end
        end
        LOCK0:   gnt0 = i_p0_req;
        LOCK1:   gnt1 = i_p1_req;
        default: ;
      endcase
    end
  end

  assign acc0     = i_p0_req & gnt0;
  assign acc1     = i_p1_req & gnt1;
  assign o_p0_gnt = gnt0;
  assign o_p1_gnt = gnt1;

  // Memory-side mux; idle lines are parked at zero.
  always_comb begin
    o_mem_addr       = '0;
    o_mem_data_write = '0;
    o_mem_we         = 1'b0;
    if (acc0) begin
      o_mem_addr       = i_p0_addr;
      o_mem_data_write = i_p0_wdata;
      o_mem_we         = i_p0_we;
    end else if (acc1) begin
      o_mem_addr       = i_p1_addr;
      o_mem_data_write = i_p1_wdata;
      o_mem_we         = i_p1_we;
    end
  end

  // Next state: lock entry/release, lock cycle counting and forced timeout.
  // A release on the final lock cycle takes priority over the timeout.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last;
    tmo_nx   = 1'b0;
    if (acc0) last_nx = 1'b0;
    if (acc1) last_nx = 1'b1;
    case (state)
      IDLE: begin
        if (acc0 && i_p0_lock) begin
          state_nx = LOCK0;
          cnt_nx   = '0;
        end else if (acc1 && i_p1_lock) begin
          state_nx = LOCK1;
          cnt_nx   = '0;
        end
      end
      LOCK0: begin
        if (acc0 && !i_p0_lock) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CW'(MAX_LOCK - 1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          last_nx  = 1'b0;
          tmo_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      LOCK1: begin
        if (acc1 && !i_p1_lock) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CW'(MAX_LOCK - 1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          last_nx  = 1'b1;
          tmo_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, arbitration history and the one-deep read-valid pipeline.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
      tmo   <= 1'b0;
      rv0   <= 1'b0;
      rv1   <= 1'b0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
      tmo   <= tmo_nx;
      rv0   <= acc0 & ~i_p0_we;
      rv1   <= acc1 & ~i_p1_we;
    end
  end

  // A strobe still in flight when reset arrives is suppressed immediately.
  assign o_p0_rvalid    = rv0 & ~i_rst;
  assign o_p1_rvalid    = rv1 & ~i_rst;
  assign o_lock_timeout = tmo & ~i_rst;
  assign o_p0_rdata     = i_mem_data_read;
  assign o_p1_rdata     = i_mem_data_read;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-cycle vector table plus a randomized alternation
// sequence; read data is checked through a scoreboard against a shadow memory.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
  logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic       p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we, lock_timeout;
  logic [7:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       load;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(8), .DW(8), .MAX_LOCK(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr),
    .i_p0_wdata(p0_wdata), .i_p0_lock(p0_lock),
    .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr),
    .i_p1_wdata(p1_wdata), .i_p1_lock(p1_lock),
    .o_p0_gnt(p0_gnt), .o_p1_gnt(p1_gnt),
    .o_p0_rvalid(p0_rvalid), .o_p1_rvalid(p1_rvalid),
    .o_p0_rdata(p0_rdata), .o_p1_rdata(p1_rdata),
    .o_mem_addr(mem_addr), .o_mem_data_write(mem_wdata), .o_mem_we(mem_we),
    .i_mem_data_read(mem_rdata), .o_lock_timeout(lock_timeout)
  );

  // Synchronous single-port memory with a one-cycle read latency.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    bit       rst;
    bit       r0, w0, l0;
    bit [7:0] a0, d0;
    bit       r1, w1, l1;
    bit [7:0] a1, d1;
    bit       g0, g1, tmo, rv0, rv1;
  } vec_t;

  typedef struct {
    bit       port;
    bit [7:0] data;
  } sb_t;

  vec_t     vecs[$];
  sb_t      sb[$];
  bit [7:0] ref_mem [256];
  int       total = 0;
  int       bad = 0;

  function automatic vec_t v(input bit rs,
                             input bit r0, w0, l0, input bit [7:0] a0, d0,
                             input bit r1, w1, l1, input bit [7:0] a1, d1,
                             input bit g0, g1, tmo, rv0, rv1);
    vec_t t;
    t.rst = rs;
    t.r0 = r0; t.w0 = w0; t.l0 = l0; t.a0 = a0; t.d0 = d0;
    t.r1 = r1; t.w1 = w1; t.l1 = l1; t.a1 = a1; t.d1 = d1;
    t.g0 = g0; t.g1 = g1; t.tmo = tmo; t.rv0 = rv0; t.rv1 = rv1;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, check combinational and registered outputs mid-cycle,
  // then advance past the next rising edge.
  task automatic apply(input vec_t t);
    bit [7:0] ea, ed;
    bit       ewe;
    sb_t      e;
    rst = t.rst; load = t.rst;
    p0_req = t.r0; p0_we = t.w0; p0_lock = t.l0; p0_addr = t.a0; p0_wdata = t.d0;
    p1_req = t.r1; p1_we = t.w1; p1_lock = t.l1; p1_addr = t.a1; p1_wdata = t.d1;
    @(negedge clk);
    ea  = t.g0 ? t.a0 : (t.g1 ? t.a1 : 8'h00);
    ed  = t.g0 ? t.d0 : (t.g1 ? t.d1 : 8'h00);
    ewe = t.g0 ? t.w0 : (t.g1 ? t.w1 : 1'b0);
    chk("gnt0", 32'(p0_gnt), 32'(t.g0));
    chk("gnt1", 32'(p1_gnt), 32'(t.g1));
    chk("mem_we", 32'(mem_we), 32'(ewe));
    chk("mem_addr", 32'(mem_addr), 32'(ea));
    chk("mem_wdata", 32'(mem_wdata), 32'(ed));
    chk("lock_timeout", 32'(lock_timeout), 32'(t.tmo));
    chk("rvalid0", 32'(p0_rvalid), 32'(t.rv0));
    chk("rvalid1", 32'(p1_rvalid), 32'(t.rv1));
    if (p0_rvalid || p1_rvalid) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("rv_port", 32'(p1_rvalid), 32'(e.port));
        chk("rdata", 32'(p1_rvalid ? p1_rdata : p0_rdata), 32'(e.data));
      end
    end
    if (t.rst) begin
      sb.delete();
    end else begin
      if (t.g0 && !t.w0) sb.push_back('{1'b0, ref_mem[t.a0]});
      if (t.g1 && !t.w1) sb.push_back('{1'b1, ref_mem[t.a1]});
      if (t.g0 && t.w0) ref_mem[t.a0] = t.d0;
      if (t.g1 && t.w1) ref_mem[t.a1] = t.d1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit turn;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);

    //                  rst  p0: r w l addr  data    p1: r w l addr  data    g0 g1 tmo rv0 rv1
    // reset
    vecs.push_back(v(1, 1,0,0,8'h10,8'h00, 1,0,0,8'h20,8'h00, 0,0,0,0,0));
    vecs.push_back(v(1, 1,0,0,8'h10,8'h00, 1,0,0,8'h20,8'h00, 0,0,0,0,0));
    // both read continuously: alternate starting with port 0
    vecs.push_back(v(0, 1,0,0,8'h10,8'h00, 1,0,0,8'h20,8'h00, 1,0,0,0,0));
    vecs.push_back(v(0, 1,0,0,8'h10,8'h00, 1,0,0,8'h20,8'h00, 0,1,0,1,0));
    vecs.push_back(v(0, 1,0,0,8'h10,8'h00, 1,0,0,8'h20,8'h00, 1,0,0,0,1));
    vecs.push_back(v(0, 1,0,0,8'h10,8'h00, 1,0,0,8'h20,8'h00, 0,1,0,1,0));
    vecs.push_back(v(0, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,1));
    // p1 write A5 -> 0x33, then read it back
    vecs.push_back(v(0, 0,0,0,8'h00,8'h00, 1,1,0,8'h33,8'hA5, 0,1,0,0,0));
    vecs.push_back(v(0, 0,0,0,8'h00,8'h00, 1,0,0,8'h33,8'h00, 0,1,0,0,0));
    vecs.push_back(v(0, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,1));
    // p0 lock, 3 locked accesses, release on the final lock cycle; p1 blocked
    vecs.push_back(v(0, 1,0,1,8'h50,8'h00, 1,0,0,8'h40,8'h00, 1,0,0,0,0));
    vecs.push_back(v(0, 1,1,1,8'h51,8'h11, 1,0,0,8'h40,8'h00, 1,0,0,1,0));
    vecs.push_back(v(0, 1,0,1,8'h51,8'h00, 1,0,0,8'h40,8'h00, 1,0,0,0,0));
    vecs.push_back(v(0, 1,0,1,8'h52,8'h00, 1,0,0,8'h40,8'h00, 1,0,0,1,0));
    vecs.push_back(v(0, 1,0,0,8'h53,8'h00, 1,0,0,8'h40,8'h00, 1,0,0,1,0));
    vecs.push_back(v(0, 0,0,0,8'h00,8'h00, 1,0,0,8'h40,8'h00, 0,1,0,1,0));
    vecs.push_back(v(0, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,1));
    // p0 lock then idle: timeout, p1 wins the tie right after (last=0)
    vecs.push_back(v(0, 1,0,1,8'h60,8'h00, 1,0,0,8'h61,8'h00, 1,0,0,0,0));
    vecs.push_back(v(0, 0,0,0,8'h00,8'h00, 1,0,0,8'h61,8'h00, 0,0,0,1,0));
    vecs.push_back(v(0, 0,0,0,8'h00,8'h00, 1,0,0,8'h61,8'h00, 0,0,0,0,0));
    vecs.push_back(v(0, 0,0,0,8'h00,8'h00, 1,0,0,8'h61,8'h00, 0,0,0,0,0));
    vecs.push_back(v(0, 0,0,0,8'h00,8'h00, 1,0,0,8'h61,8'h00, 0,0,0,0,0));
    vecs.push_back(v(0, 1,0,0,8'h62,8'h00, 1,0,0,8'h61,8'h00, 0,1,1,0,0));
    vecs.push_back(v(0, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,1));
    // p1 lock, owner idle mid-lock, access accepted in the timeout cycle
    vecs.push_back(v(0, 0,0,0,8'h00,8'h00, 1,0,1,8'h70,8'h00, 0,1,0,0,0));
    vecs.push_back(v(0, 1,0,0,8'h71,8'h00, 1,1,1,8'h70,8'h3C, 0,1,0,0,1));
    vecs.push_back(v(0, 1,0,0,8'h71,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,0));
    vecs.push_back(v(0, 1,0,0,8'h71,8'h00, 1,0,1,8'h70,8'h00, 0,1,0,0,0));
    vecs.push_back(v(0, 1,0,0,8'h71,8'h00, 1,0,1,8'h72,8'h00, 0,1,0,0,1));
    vecs.push_back(v(0, 1,0,0,8'h71,8'h00, 0,0,0,8'h00,8'h00, 1,0,1,0,1));
    vecs.push_back(v(0, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,1,0));
    // reset during a lock with a read in flight
    vecs.push_back(v(0, 0,0,0,8'h00,8'h00, 1,0,1,8'h80,8'h00, 0,1,0,0,0));
    vecs.push_back(v(1, 1,0,0,8'h90,8'h00, 1,0,0,8'h91,8'h00, 0,0,0,0,0));
    vecs.push_back(v(0, 1,0,0,8'h90,8'h00, 1,0,0,8'h91,8'h00, 1,0,0,0,0));
    vecs.push_back(v(0, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,1,0));

    foreach (vecs[i]) apply(vecs[i]);

    // Randomized addresses/data with both ports reading every cycle after reset.
    apply(v(1, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,0));
    turn = 1'b0;
    for (int k = 0; k < 8; k++) begin
      apply(v(0, 1,0,0,8'($urandom),8'($urandom), 1,0,0,8'($urandom),8'($urandom),
              ~turn, turn, 0, (k > 0) && turn, (k > 0) && ~turn));
      turn = ~turn;
    end
    apply(v(0, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,1));
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
